// File: rtl/spi_cmd_ctrl.sv
// Command sequencer for the 48-bit SPI slave: captures each received frame, executes
// a register write/read against the config register file and stages the response word.
module spi_cmd_ctrl #(
  parameter int          NREG      = 8,
  parameter logic [6:0]  STAT_ADDR = 7'h7F,
  parameter int          FRAME_W   = 48
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 spi_done,
  input  logic [FRAME_W-1:0]   spi_rdata,
  output logic [FRAME_W-1:0]   spi_tdata,
  output logic                 spi_ten,
  input  logic [31:0]          stat_in,
  output logic [NREG*32-1:0]   cfg_flat,
  output logic                 cfg_we,
  output logic [6:0]           cfg_addr,
  output logic [15:0]          frame_cnt,
  output logic [7:0]           err_cnt,
  output logic                 overrun
);

  // state | meaning
  // IDLE  | waiting for a frame-done rise
  // CAPT  | latch the received frame
  // EXEC  | validate, perform write/read, build payload
  // RESP  | publish response word, count the frame
  typedef enum logic [1:0] {IDLE, CAPT, EXEC, RESP} state_t;

  localparam logic [7:0] NREG_L = 8'(NREG);

  state_t                   state_q, state_d;
  logic [2:0]               sync_q;
  logic [FRAME_W-1:0]       frame_q, frame_d;
  logic [NREG-1:0][31:0]    regs_q, regs_d;
  logic [7:0]               exp_seq_q, exp_seq_d;
  logic                     nack_q, nack_d;
  logic [31:0]              payload_q, payload_d;
  logic [FRAME_W-1:0]       tdata_q, tdata_d;
  logic                     ten_q, ten_d;
  logic                     we_q, we_d;
  logic [6:0]               waddr_q, waddr_d;
  logic [15:0]              frame_cnt_q, frame_cnt_d;
  logic [7:0]               err_cnt_q, err_cnt_d;
  logic                     ovr_q, ovr_d;

  logic        rise;
  logic        f_rw;
  logic [6:0]  f_addr;
  logic [7:0]  f_seq;
  logic [31:0] f_data;
  logic        is_stat, addr_ok, seq_ok;
  logic [31:0] rd_reg;
  logic [1:0]  err_inc;
  logic [8:0]  err_sum;

  assign rise   = sync_q[1] & ~sync_q[2];
  assign f_rw   = frame_q[47];
  assign f_addr = frame_q[46:40];
  assign f_seq  = frame_q[39:32];
  assign f_data = frame_q[31:0];

  assign is_stat = ~f_rw & (f_addr == STAT_ADDR);
  assign addr_ok = ({1'b0, f_addr} < NREG_L) | is_stat;
  assign seq_ok  = (f_seq == exp_seq_q);

  always_comb begin
    rd_reg = '0;
    for (int i = 0; i < NREG; i++) begin
      if (f_addr == 7'(i)) rd_reg = regs_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    regs_d      = regs_q;
    exp_seq_d   = exp_seq_q;
    nack_d      = nack_q;
    payload_d   = payload_q;
    tdata_d     = tdata_q;
    ten_d       = ten_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    frame_cnt_d = frame_cnt_q;
    ovr_d       = ovr_q;
    err_inc     = 2'd0;

    // a rise while busy is dropped, but still counted as an error
    if (rise && state_q != IDLE) begin
      ovr_d   = 1'b1;
      err_inc = err_inc + 2'd1;
    end

    case (state_q)
      IDLE: if (rise) state_d = CAPT;
      CAPT: begin
        frame_d = spi_rdata;
        state_d = EXEC;
      end
      EXEC: begin
        nack_d    = ~addr_ok | ~seq_ok;
        exp_seq_d = f_seq + 8'd1;
        if (!addr_ok || !seq_ok) err_inc = err_inc + 2'd1;
        if (!addr_ok)     payload_d = 32'hDEAD_BEEF;
        else if (f_rw)    payload_d = f_data;
        else if (is_stat) payload_d = stat_in;
        else              payload_d = rd_reg;
        if (f_rw && addr_ok) begin
          we_d    = 1'b1;
          waddr_d = f_addr;
          for (int i = 0; i < NREG; i++) begin
            if (f_addr == 7'(i)) regs_d[i] = f_data;
          end
        end
        state_d = RESP;
      end
      RESP: begin
        tdata_d     = {~nack_q, f_addr, f_seq, payload_q};
        ten_d       = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    err_sum   = {1'b0, err_cnt_q} + {7'd0, err_inc};
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      frame_q     <= '0;
      regs_q      <= '0;
      exp_seq_q   <= '0;
      nack_q      <= 1'b0;
      payload_q   <= '0;
      tdata_q     <= '0;
      ten_q       <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[1:0], spi_done};
      frame_q     <= frame_d;
      regs_q      <= regs_d;
      exp_seq_q   <= exp_seq_d;
      nack_q      <= nack_d;
      payload_q   <= payload_d;
      tdata_q     <= tdata_d;
      ten_q       <= ten_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      ovr_q       <= ovr_d;
    end
  end

  assign spi_tdata = tdata_q;
  assign spi_ten   = ten_q;
  assign cfg_flat  = regs_q;
  assign cfg_we    = we_q;
  assign cfg_addr  = waddr_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: write/read/status frames, nack cases, overrun,
// counter wrap/saturation and asynchronous reset mid-frame.
module tb_spi_cmd_ctrl;

  logic          clk;
  logic          rstb;
  logic          spi_done;
  logic [47:0]   spi_rdata;
  logic [47:0]   spi_tdata;
  logic          spi_ten;
  logic [31:0]   stat_in;
  logic [255:0]  cfg_flat;
  logic          cfg_we;
  logic [6:0]    cfg_addr;
  logic [15:0]   frame_cnt;
  logic [7:0]    err_cnt;
  logic          overrun;

  int total = 0;
  int bad   = 0;

  logic [47:0]      tdata_at [10];
  int               we_cnt;
  int               we_idx;
  logic [6:0]       we_addr;
  logic [7:0][31:0] model;

  spi_cmd_ctrl dut (
    .clk       (clk),
    .rstb      (rstb),
    .spi_done  (spi_done),
    .spi_rdata (spi_rdata),
    .spi_tdata (spi_tdata),
    .spi_ten   (spi_ten),
    .stat_in   (stat_in),
    .cfg_flat  (cfg_flat),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One frame over 10 clk; dbl adds a second done rise 2 clk after the first.
  task automatic send(input logic [47:0] f, input bit dbl);
    we_cnt  = 0;
    we_idx  = -1;
    we_addr = '0;
    @(negedge clk);
    spi_rdata = f;
    spi_done  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      tdata_at[i] = spi_tdata;
      if (cfg_we) begin
        we_cnt++;
        we_idx  = i;
        we_addr = cfg_addr;
      end
      @(negedge clk);
      if (dbl && i == 0) spi_done = 1'b0;
      if (dbl && i == 1) spi_done = 1'b1;
      if (i == 3)        spi_done = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tdata"}, spi_tdata, 48'h0);
    chk({tag, "_ten"},   spi_ten, 1'b0);
    chk({tag, "_flat"},  cfg_flat, 256'h0);
    chk({tag, "_we"},    cfg_we, 1'b0);
    chk({tag, "_addr"},  cfg_addr, 7'h0);
    chk({tag, "_fcnt"},  frame_cnt, 16'h0);
    chk({tag, "_ecnt"},  err_cnt, 8'h0);
    chk({tag, "_ovr"},   overrun, 1'b0);
  endtask

  initial begin
    model     = '0;
    rstb      = 1'b0;
    spi_done  = 1'b0;
    spi_rdata = '0;
    stat_in   = 32'h0;
    #3;
    chk_reset_vals("rst0");
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    // write reg3, seq 0
    send(48'h8300_0012_3456, 1'b0);
    model[3] = 32'h0012_3456;
    chk("wr_flat",   cfg_flat, model);
    chk("wr_wecnt",  we_cnt, 1);
    chk("wr_weidx",  we_idx, 4);
    chk("wr_weaddr", we_addr, 7'd3);
    chk("wr_t2",     tdata_at[4], 48'h0);
    chk("wr_t3",     tdata_at[5], 48'h8300_0012_3456);
    chk("wr_ten",    spi_ten, 1'b1);
    chk("wr_fcnt",   frame_cnt, 16'd1);
    chk("wr_ecnt",   err_cnt, 8'd0);

    // status read, seq 1
    stat_in = 32'hCAFE_F00D;
    send(48'h7F01_0000_0000, 1'b0);
    chk("st_tdata", spi_tdata, 48'hFF01_CAFE_F00D);
    chk("st_wecnt", we_cnt, 0);
    chk("st_fcnt",  frame_cnt, 16'd2);

    // write to addr 10 with seq 5 (2 expected)
    send(48'h8A05_0000_0001, 1'b0);
    chk("bad_tdata", spi_tdata, 48'h0A05_DEAD_BEEF);
    chk("bad_ecnt",  err_cnt, 8'd1);
    chk("bad_wecnt", we_cnt, 0);
    chk("bad_flat",  cfg_flat, model);
    chk("bad_fcnt",  frame_cnt, 16'd3);

    // read reg3 with seq 6: resynchronised, acked
    send(48'h0306_0000_0000, 1'b0);
    chk("rd_tdata", spi_tdata, 48'h8306_0012_3456);
    chk("rd_ecnt",  err_cnt, 8'd1);

    // write to STAT_ADDR is an invalid address
    send(48'hFF07_1111_1111, 1'b0);
    chk("wst_tdata", spi_tdata, 48'h7F07_DEAD_BEEF);
    chk("wst_ecnt",  err_cnt, 8'd2);
    chk("wst_wecnt", we_cnt, 0);
    chk("wst_flat",  cfg_flat, model);

    // valid write with seq mismatch (8 expected): write happens, nacked
    send(48'h8009_A5A5_5A5A, 1'b0);
    model[0] = 32'hA5A5_5A5A;
    chk("wsq_tdata",  spi_tdata, 48'h0009_A5A5_5A5A);
    chk("wsq_ecnt",   err_cnt, 8'd3);
    chk("wsq_wecnt",  we_cnt, 1);
    chk("wsq_weaddr", we_addr, 7'd0);
    chk("wsq_flat",   cfg_flat, model);

    // overrun: second rise lands while busy
    send(48'h870A_0000_0077, 1'b1);
    model[7] = 32'h0000_0077;
    chk("ovr_flag",  overrun, 1'b1);
    chk("ovr_ecnt",  err_cnt, 8'd4);
    chk("ovr_fcnt",  frame_cnt, 16'd7);
    chk("ovr_wecnt", we_cnt, 1);
    chk("ovr_tdata", spi_tdata, 48'h870A_0000_0077);
    chk("ovr_flat",  cfg_flat, model);

    // frame counter wrap
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frame_cnt_q;
    send(48'h070B_0000_0000, 1'b0);
    chk("wrap_fcnt",  frame_cnt, 16'h0000);
    chk("wrap_tdata", spi_tdata, 48'h870B_0000_0077);
    chk("wrap_ecnt",  err_cnt, 8'd4);

    // 300 bad-address reads with correct seq: error counter saturates
    for (int i = 0; i < 300; i++) begin
      send({8'h50, 8'(12 + i), 32'h0}, 1'b0);
      if (i == 249) chk("sat_250", err_cnt, 8'hFE);
      if (i == 250) chk("sat_251", err_cnt, 8'hFF);
    end
    chk("sat_300",   err_cnt, 8'hFF);
    chk("sat_tdata", spi_tdata, 48'h5037_DEAD_BEEF);
    chk("sat_fcnt",  frame_cnt, 16'd300);
    chk("sat_ovr",   overrun, 1'b1);

    // asynchronous reset mid-frame
    @(negedge clk);
    spi_rdata = 48'h8200_0000_0042;
    spi_done  = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rstb = 1'b0;
    #1;
    chk_reset_vals("rst1");
    spi_done = 1'b0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    // first frame after reset uses seq 0
    model = '0;
    send(48'h8100_1234_5678, 1'b0);
    model[1] = 32'h1234_5678;
    chk("post_tdata", spi_tdata, 48'h8100_1234_5678);
    chk("post_flat",  cfg_flat, model);
    chk("post_fcnt",  frame_cnt, 16'd1);
    chk("post_ecnt",  err_cnt, 8'd0);
    chk("post_ovr",   overrun, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
- Command sequencer for the 48-bit SPI slave, running in the system clock domain.
- Detects frame completion from the SPI slave and captures each received frame.
- Decodes each frame as a register write or read against an internal configuration register file.
- Stages the 48-bit response word for the slave to shift out during the next frame, and drives the slave's transmit enable.

Parameters:
- NREG, 8: number of 32-bit configuration registers, at addresses 0..NREG-1. Legal range 1..126.
- STAT_ADDR, 7'h7F: read-only address that returns the stat_in word.
- FRAME_W, 48: SPI frame width. Fixed at 48; any other value is illegal.

Ports:
- clk  in  1  system clock
- rstb  in  1  asynchronous active-low reset
- spi_done  in  1  frame-done level from the SPI slave (sck domain, asynchronous to clk)
- spi_rdata  in  48  received frame; stable from the done rise until the next frame end
- spi_tdata  out  48  response word loaded by the slave when its bit count is zero
- spi_ten  out  1  slave MISO drive enable
- stat_in  in  32  live status word, sampled on a read of STAT_ADDR
- cfg_flat  out  NREG*32  register file contents; register i occupies bits [32i+31:32i]
- cfg_we  out  1  one-cycle strobe on a successful write
- cfg_addr  out  7  address of the last successful write
- frame_cnt  out  16  number of accepted frames, wraps modulo 2^16
- err_cnt  out  8  error count, saturates at 8'hFF
- overrun  out  1  sticky flag: a frame arrived while the FSM was not in IDLE

Behaviour:
- Clock and reset: one clock, clk. rstb is asynchronous and active-low.
- Reset values:
  - spi_tdata = 48'h0000_0000_0000, spi_ten = 0
  - cfg_flat = 0, cfg_we = 0, cfg_addr = 0
  - frame_cnt = 0, err_cnt = 0, overrun = 0
  - expected sequence = 0, FSM = IDLE, synchroniser flops = 0
- Reset asserted mid-frame aborts all activity immediately. The first frame after reset is handled normally.
- Synchroniser and edge detect:
  - spi_done passes through a 2-flop synchroniser, then a third flop.
  - rise = sync & ~sync_d.
  - rise is seen at cycle T, i.e. 2-3 clk after the spi_done edge.
- Frame format, MSB first:
  - [47] rw: 1 = write, 0 = read
  - [46:40] address
  - [39:32] seq
  - [31:0] data
- FSM states: IDLE, CAPT, EXEC, RESP.
  - IDLE: on rise go to CAPT.
  - CAPT (cycle T+1): register spi_rdata into frame_q. Go to EXEC.
  - EXEC (cycle T+2): validate, then perform the write or read; see rules below. Go to RESP.
  - RESP (cycle T+3): load spi_tdata, set spi_ten = 1, increment frame_cnt. Go to IDLE.
  - spi_tdata is therefore updated 3 clk after rise. Integration requires clk ≥ 4 × sck so this completes before the next frame's first negedge.
- Validation in EXEC:
  - The address is valid if addr < NREG, or if it is a read of STAT_ADDR.
  - seq_ok = (seq == expected sequence). The expected sequence becomes seq+1 after every frame, whatever the outcome, so the check resynchronises.
  - A bad address or a seq mismatch increments err_cnt once per frame (saturating) and sets nack.
- Write with a valid address:
  - Performed even if seq mismatches.
  - reg[addr] ← data; cfg_we = 1 for exactly the EXEC→RESP cycle; cfg_addr = addr.
  - A write to STAT_ADDR is an invalid address.
- Read: the response data is reg[addr], or stat_in sampled in EXEC for STAT_ADDR.
- Response word:
  - Layout: {ack, addr, seq, payload}.
  - ack = ~nack.
  - payload = written data for a write, read value for a read, 32'hDEAD_BEEF on a bad address.
- Overrun: a rise outside IDLE is dropped, sets overrun (cleared only by reset), and increments err_cnt.
- spi_ten stays 1 from the first RESP until reset.
- frame_cnt increments for every accepted frame, including nacked ones; it wraps from FFFF to 0000.

Test Plan:
- Reset: assert rstb=0 mid-operation → all outputs equal their reset values immediately, with no clk edge required.
- Write: frame 48'h8300_0012_3456 (write, addr 3, seq 0) → reg3 = 0012_3456, cfg_we pulses 1 clk with cfg_addr = 3, spi_tdata = 48'h8300_0012_3456 at T+3, frame_cnt = 1.
- Read status: stat_in = CAFE_F00D, frame 48'h7F01_0000_0000 (read, STAT_ADDR, seq 1) → spi_tdata = 48'hFF01_CAFE_F00D.
- Bad address and sequence: frame 48'h8A05_0000_0001 (write, addr 10, NREG=8, seq 5 where 2 is expected) → no write occurs, spi_tdata = 48'h0A05_DEAD_BEEF, err_cnt increments by exactly 1. Next frame with seq 6 → ack = 1.
- Overrun: drive a second spi_done rise 2 clk after the first → overrun = 1, err_cnt increments, only one frame is counted.
- Counter limits: preload frame_cnt = FFFF and send one frame → frame_cnt = 0000. Drive 300 error frames → err_cnt holds at FF.
